// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one SRAM port between three requesters: the display read stream,
// the camera write stream and a host single-word port. Stream FIFO levels set
// the priorities. Stream grants are bounded bursts, and a one-cycle
// turnaround is inserted whenever the bus direction has to change.
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst       in   1      asynchronous reset, active-high
//   rd_level  in   LVL_W  words held in the display read FIFO
//   wr_level  in   LVL_W  words held in the camera write FIFO
//   host_req  in   1      host access pending, held until host_ack
//   host_we   in   1      host direction (1 = write), stable while host_req
//   host_ack  out  1      one-cycle pulse, host access performed this cycle
//   gnt       out  3      one-hot grant [0]=read [1]=write [2]=host, 0 = idle
//   beat      out  1      SRAM cycle issued this cycle for the granted requester
//   dir_wr    out  1      current bus direction (1 = write)
//   rd_beats  out  16     saturating count of read beats since reset
//   wr_beats  out  16     saturating count of write beats (stream + host)
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int LVL_W      = 8,
    parameter int BURST_LEN  = 16,
    parameter int RD_URGENT  = 32,
    parameter int RD_LOW     = 192,
    parameter int RD_FULL    = 240,
    parameter int WR_URGENT  = 240,
    parameter int WR_HIGH    = 160,
    parameter int STARVE_MAX = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LVL_W-1:0] rd_level,
    input  logic [LVL_W-1:0] wr_level,
    input  logic             host_req,
    input  logic             host_we,
    output logic             host_ack,
    output logic [2:0]       gnt,
    output logic             beat,
    output logic             dir_wr,
    output logic [15:0]      rd_beats,
    output logic [15:0]      wr_beats
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TURN  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_HOST  = 2'd3;

    // Thresholds recast to the level width so every comparison is same-width.
    localparam logic [LVL_W-1:0] RD_URGENT_L = LVL_W'(RD_URGENT);
    localparam logic [LVL_W-1:0] RD_LOW_L    = LVL_W'(RD_LOW);
    localparam logic [LVL_W-1:0] RD_FULL_L   = LVL_W'(RD_FULL);
    localparam logic [LVL_W-1:0] WR_URGENT_L = LVL_W'(WR_URGENT);
    localparam logic [LVL_W-1:0] WR_HIGH_L   = LVL_W'(WR_HIGH);

    localparam int               AGE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

    // +1 keeps the width at least one bit when BURST_LEN is 1.
    localparam int               K_W    = $clog2(BURST_LEN + 1);
    localparam logic [K_W-1:0]   K_LAST = K_W'(BURST_LEN - 1);

    logic [1:0]       state;
    logic [K_W-1:0]   beat_k;
    logic [AGE_W-1:0] host_age;
    logic [AGE_W-1:0] wr_age;

    logic       rd_urgent;
    logic       rd_normal;
    logic       rd_ok;
    logic       wr_high;
    logic       wr_urgent;
    logic       wr_ok;
    logic       host_starved;
    logic [2:0] win;
    logic       win_dir;

    // Level decode. Levels are used as they arrive, without registering.
    assign rd_urgent    = rd_level < RD_URGENT_L;
    assign rd_normal    = rd_level < RD_LOW_L;
    assign rd_ok        = rd_level < RD_FULL_L;
    assign wr_high      = wr_level >= WR_HIGH_L;
    assign wr_urgent    = (wr_level >= WR_URGENT_L) || (wr_high && (wr_age >= AGE_MAX));
    assign wr_ok        = wr_level != '0;
    assign host_starved = host_req && (host_age >= AGE_MAX);

    // Fixed-order priority pick; only acted upon while idle.
    always_comb begin
        win = 3'b000;
        if (rd_urgent)         win = 3'b001;
        else if (wr_urgent)    win = 3'b010;
        else if (host_starved) win = 3'b100;
        else if (rd_normal)    win = 3'b001;
        else if (wr_high)      win = 3'b010;
        else if (host_req)     win = 3'b100;
    end

    assign win_dir = win[1] | (win[2] & host_we);

    // Beat strobe is combinational so a failing eligibility suppresses the
    // beat in the very cycle it is seen; state is IDLE during reset, so the
    // strobe drops as soon as rst rises.
    assign beat     = ((state == S_BURST) && ((gnt[0] && rd_ok) || (gnt[1] && wr_ok)))
                    || (state == S_HOST);
    assign host_ack = state == S_HOST;

    // Main sequencer: arbitration in IDLE, optional turnaround, then a
    // bounded burst or a single host cycle, always returning through IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            gnt    <= 3'b000;
            dir_wr <= 1'b1;
            beat_k <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win != 3'b000) begin
                        gnt    <= win;
                        beat_k <= '0;
                        if (win_dir != dir_wr) begin
                            dir_wr <= win_dir;
                            state  <= S_TURN;
                        end else begin
                            state <= win[2] ? S_HOST : S_BURST;
                        end
                    end
                end
                S_TURN: begin
                    state <= gnt[2] ? S_HOST : S_BURST;
                end
                S_BURST: begin
                    if (!beat || (beat_k == K_LAST)) begin
                        state <= S_IDLE;
                        gnt   <= 3'b000;
                    end else begin
                        beat_k <= beat_k + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= 3'b000;
                end
            endcase
        end
    end

    // Starvation ages: count waiting cycles outside the requester's own
    // grant, clear when it wins arbitration, saturate at STARVE_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_age <= '0;
            wr_age   <= '0;
        end else begin
            if ((state == S_IDLE) && win[2])
                host_age <= '0;
            else if (host_req && !gnt[2] && (host_age != AGE_MAX))
                host_age <= host_age + 1'b1;

            if ((state == S_IDLE) && win[1])
                wr_age <= '0;
            else if (wr_high && !gnt[1] && (wr_age != AGE_MAX))
                wr_age <= wr_age + 1'b1;
        end
    end

    // Beat counters split by bus direction, so host writes land in wr_beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_beats <= 16'h0000;
            wr_beats <= 16'h0000;
        end else if (beat) begin
            if (dir_wr) begin
                if (wr_beats != 16'hFFFF) wr_beats <= wr_beats + 16'h0001;
            end else begin
                if (rd_beats != 16'hFFFF) rd_beats <= rd_beats + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Directed bench for sram_port_arbiter. Each test pushes per-cycle stimulus
// together with the expected grant/beat/direction/ack onto a scoreboard
// queue; the queue is then replayed one cycle at a time against the DUT.
// Expected beat totals are accumulated from the queued expectations.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

    typedef struct packed {
        logic [7:0] rd;
        logic [7:0] wr;
        logic       hreq;
        logic       hwe;
        logic [2:0] gnt;
        logic       beat;
        logic       dir;
        logic       ack;
    } step_t;

    logic        clock;
    logic        reset;
    logic [7:0]  rdLevel;
    logic [7:0]  wrLevel;
    logic        hostReq;
    logic        hostWe;
    logic        hostAck;
    logic [2:0]  gnt;
    logic        beat;
    logic        dirWr;
    logic [15:0] rdBeats;
    logic [15:0] wrBeats;

    int          total;
    int          bad;
    int          stepNo;
    int          expRd;
    int          expWr;
    step_t       sbQ[$];

    sram_port_arbiter dut (
        .clk      (clock),
        .rst      (reset),
        .rd_level (rdLevel),
        .wr_level (wrLevel),
        .host_req (hostReq),
        .host_we  (hostWe),
        .host_ack (hostAck),
        .gnt      (gnt),
        .beat     (beat),
        .dir_wr   (dirWr),
        .rd_beats (rdBeats),
        .wr_beats (wrBeats)
    );

    // Free-running 10 time-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s step=%0d observed=%0h expected=%0h", tag, stepNo, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] rd, input logic [7:0] wr,
                                 input logic hreq, input logic hwe,
                                 input logic [2:0] g, input logic b,
                                 input logic d, input logic a);
        step_t s;
        s.rd   = rd;
        s.wr   = wr;
        s.hreq = hreq;
        s.hwe  = hwe;
        s.gnt  = g;
        s.beat = b;
        s.dir  = d;
        s.ack  = a;
        sbQ.push_back(s);
    endtask

    // Replay the queue: drive on the falling edge, sample 1 unit later.
    task automatic runSteps();
        step_t s;
        while (sbQ.size() > 0) begin
            s = sbQ.pop_front();
            @(negedge clock);
            rdLevel = s.rd;
            wrLevel = s.wr;
            hostReq = s.hreq;
            hostWe  = s.hwe;
            #1;
            checkOutput("gnt",      16'(gnt),     16'(s.gnt));
            checkOutput("beat",     16'(beat),    16'(s.beat));
            checkOutput("dir_wr",   16'(dirWr),   16'(s.dir));
            checkOutput("host_ack", 16'(hostAck), 16'(s.ack));
            if (s.beat) begin
                if (s.dir) expWr++;
                else       expRd++;
            end
            stepNo++;
        end
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_rd_beats"}, rdBeats, 16'(expRd));
        checkOutput({tag, "_wr_beats"}, wrBeats, 16'(expWr));
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        stepNo  = 0;
        expRd   = 0;
        expWr   = 0;
        reset   = 1'b1;
        rdLevel = 8'd200;
        wrLevel = 8'd0;
        hostReq = 1'b0;
        hostWe  = 1'b0;

        // Reset state.
        repeat (2) @(negedge clock);
        #1;
        checkOutput("rst_gnt",      16'(gnt),     16'h0);
        checkOutput("rst_beat",     16'(beat),    16'h0);
        checkOutput("rst_dir_wr",   16'(dirWr),   16'h1);
        checkOutput("rst_host_ack", 16'(hostAck), 16'h0);
        checkCounters("rst");
        @(negedge clock);
        reset = 1'b0;

        // Urgent read beats urgent write; turnaround both ways.
        $display("[TB] urgent read vs urgent write");
        applyStimulus(8'd10, 8'd250, 0, 0, 3'b000, 0, 1, 0);
        applyStimulus(8'd10, 8'd250, 0, 0, 3'b001, 0, 0, 0);
        for (int i = 0; i < 16; i++) applyStimulus(8'd10, 8'd250, 0, 0, 3'b001, 1, 0, 0);
        applyStimulus(8'd200, 8'd250, 0, 0, 3'b000, 0, 0, 0);
        applyStimulus(8'd200, 8'd250, 0, 0, 3'b010, 0, 1, 0);
        for (int i = 0; i < 16; i++) applyStimulus(8'd200, 8'd250, 0, 0, 3'b010, 1, 1, 0);
        applyStimulus(8'd200, 8'd0, 0, 0, 3'b000, 0, 1, 0);
        runSteps();
        checkCounters("urgent");

        // Read burst cut short when the read FIFO fills at beat 5.
        $display("[TB] read burst ended by full level");
        applyStimulus(8'd100, 8'd0, 0, 0, 3'b000, 0, 1, 0);
        applyStimulus(8'd100, 8'd0, 0, 0, 3'b001, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(8'd100, 8'd0, 0, 0, 3'b001, 1, 0, 0);
        applyStimulus(8'd240, 8'd0, 0, 0, 3'b001, 0, 0, 0);
        applyStimulus(8'd240, 8'd0, 0, 0, 3'b000, 0, 0, 0);
        applyStimulus(8'd200, 8'd0, 0, 0, 3'b000, 0, 0, 0);
        runSteps();
        checkCounters("full");

        // Normal write starves behind normal reads until its age saturates.
        $display("[TB] write starvation promotion");
        for (int r = 0; r < 4; r++) begin
            applyStimulus(8'd100, 8'd200, 0, 0, 3'b000, 0, 0, 0);
            for (int i = 0; i < 16; i++) applyStimulus(8'd100, 8'd200, 0, 0, 3'b001, 1, 0, 0);
        end
        applyStimulus(8'd100, 8'd200, 0, 0, 3'b000, 0, 0, 0);
        applyStimulus(8'd100, 8'd200, 0, 0, 3'b010, 0, 1, 0);
        for (int i = 0; i < 16; i++) applyStimulus(8'd100, 8'd200, 0, 0, 3'b010, 1, 1, 0);
        applyStimulus(8'd200, 8'd0, 0, 0, 3'b000, 0, 1, 0);
        runSteps();
        checkCounters("starve");

        // Host write with no turnaround, then host read with turnaround.
        $display("[TB] host accesses");
        applyStimulus(8'd200, 8'd0, 1, 1, 3'b000, 0, 1, 0);
        applyStimulus(8'd200, 8'd0, 1, 1, 3'b100, 1, 1, 1);
        applyStimulus(8'd200, 8'd0, 0, 0, 3'b000, 0, 1, 0);
        applyStimulus(8'd200, 8'd0, 1, 0, 3'b000, 0, 1, 0);
        applyStimulus(8'd200, 8'd0, 1, 0, 3'b100, 0, 0, 0);
        applyStimulus(8'd200, 8'd0, 1, 0, 3'b100, 1, 0, 1);
        applyStimulus(8'd200, 8'd0, 0, 0, 3'b000, 0, 0, 0);
        runSteps();
        checkCounters("host");

        // Write burst draining the write FIFO: 3 beats, ends on level 0.
        $display("[TB] write burst drained to empty");
        applyStimulus(8'd200, 8'd200, 0, 0, 3'b000, 0, 0, 0);
        applyStimulus(8'd200, 8'd3,   0, 0, 3'b010, 0, 1, 0);
        applyStimulus(8'd200, 8'd3,   0, 0, 3'b010, 1, 1, 0);
        applyStimulus(8'd200, 8'd2,   0, 0, 3'b010, 1, 1, 0);
        applyStimulus(8'd200, 8'd1,   0, 0, 3'b010, 1, 1, 0);
        applyStimulus(8'd200, 8'd0,   0, 0, 3'b010, 0, 1, 0);
        applyStimulus(8'd200, 8'd0,   0, 0, 3'b000, 0, 1, 0);
        runSteps();
        checkCounters("drain");

        // Asynchronous reset in the middle of a read burst.
        $display("[TB] reset mid-burst");
        applyStimulus(8'd100, 8'd0, 0, 0, 3'b000, 0, 1, 0);
        applyStimulus(8'd100, 8'd0, 0, 0, 3'b001, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(8'd100, 8'd0, 0, 0, 3'b001, 1, 0, 0);
        runSteps();
        #2;
        reset = 1'b1;
        #1;
        expRd = 0;
        expWr = 0;
        checkOutput("mid_rst_gnt",      16'(gnt),     16'h0);
        checkOutput("mid_rst_beat",     16'(beat),    16'h0);
        checkOutput("mid_rst_dir_wr",   16'(dirWr),   16'h1);
        checkOutput("mid_rst_host_ack", 16'(hostAck), 16'h0);
        checkCounters("mid_rst");
        rdLevel = 8'd200;
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(8'd200, 8'd0, 0, 0, 3'b000, 0, 1, 0);
        applyStimulus(8'd200, 8'd0, 0, 0, 3'b000, 0, 1, 0);
        runSteps();
        checkCounters("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
